// File: rtl/shift_pkg.sv
// Shared encodings for the serial link: bit-order convention and receiver FSM states.
package shift_pkg;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/sipo_capture.sv
// Serial-in parallel-out capture: shift register, per-word bit-order latch and bit counter.
// Emits a one-cycle word_done together with the fully assembled word.
module sipo_capture
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             dir,
  input  logic             serial_in,
  output logic [WIDTH-1:0] word,
  output logic             word_done,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr_reg, sr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             dir_reg;

  always_comb begin
    sr_next   = sr_reg;
    cnt_next  = cnt_reg;
    word_done = 1'b0;
    if (load) begin
      // A new word starts from an empty register so stale bits cannot leak in.
      if (dir == DIR_MSB_FIRST)
        sr_next = {{(WIDTH-1){1'b0}}, serial_in};
      else
        sr_next = {serial_in, {(WIDTH-1){1'b0}}};
      cnt_next = CNT_W'(1);
    end else if (shift) begin
      if (dir_reg == DIR_MSB_FIRST)
        sr_next = {sr_reg[WIDTH-2:0], serial_in};
      else
        sr_next = {serial_in, sr_reg[WIDTH-1:1]};
      if (cnt_reg == LAST_BIT) begin
        word_done = 1'b1;
        cnt_next  = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_reg  <= '0;
      cnt_reg <= '0;
      dir_reg <= DIR_LSB_FIRST;
    end else begin
      sr_reg  <= sr_next;
      cnt_reg <= cnt_next;
      if (load)
        dir_reg <= dir;
    end
  end

  assign word  = sr_next;
  assign count = cnt_reg;

endmodule

// File: rtl/serial_word_receiver.sv
// Collects a serial bit stream into WIDTH-bit words and presents them through a
// single-entry holding register with a valid/ready handshake and a sticky overrun flag.
module serial_word_receiver
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             serial_in,
  input  logic             dir,
  input  logic             sync,
  input  logic             word_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] parallel_out,
  output logic             word_valid,
  output logic             overrun,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count
);

  rx_state_t        state_reg, state_next;
  logic             load, shift;
  logic [WIDTH-1:0] word;
  logic             word_done;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] hold_reg, hold_next;
  logic             valid_reg, valid_next;
  logic             ovr_reg, ovr_next;
  logic             accept;

  // The first bit of a word, or any sync bit mid-word, restarts capture.
  assign load  = bit_valid & ((state_reg == ST_IDLE) | sync);
  assign shift = bit_valid & ~load;

  sipo_capture #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_capture (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .shift     (shift),
    .dir       (dir),
    .serial_in (serial_in),
    .word      (word),
    .word_done (word_done),
    .count     (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      hold_reg  <= '0;
      valid_reg <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      valid_reg <= valid_next;
      ovr_reg   <= ovr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    valid_next = valid_reg;
    ovr_next   = ovr_reg;
    accept     = word_done & (~valid_reg | word_ready);

    case (state_reg)
      ST_IDLE:  if (bit_valid) state_next = ST_SHIFT;
      ST_SHIFT: if (word_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    // A completion landing on a consume cycle refills the register without a gap.
    if (accept) begin
      hold_next  = word;
      valid_next = 1'b1;
    end else if (valid_reg & word_ready) begin
      valid_next = 1'b0;
    end

    if (word_done & ~accept)
      ovr_next = 1'b1;
    else if (clr_ovr)
      ovr_next = 1'b0;
  end

  assign parallel_out = hold_reg;
  assign word_valid   = valid_reg;
  assign overrun      = ovr_reg;
  assign busy         = (state_reg == ST_SHIFT);
  assign bit_count    = count;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: directed vector table, hand-written corner sequences
// and randomized traffic checked against a queue-based word-assembly model.
module tb_serial_word_receiver;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             bit_valid, serial_in, dir, sync, word_ready, clr_ovr;
  logic [WIDTH-1:0] parallel_out;
  logic             word_valid, overrun, busy;
  logic [CNT_W-1:0] bit_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_word_receiver #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bit_valid    (bit_valid),
    .serial_in    (serial_in),
    .dir          (dir),
    .sync         (sync),
    .word_ready   (word_ready),
    .clr_ovr      (clr_ovr),
    .parallel_out (parallel_out),
    .word_valid   (word_valid),
    .overrun      (overrun),
    .busy         (busy),
    .bit_count    (bit_count)
  );

  typedef struct {
    logic             bv, si, d, sy, rdy, clr;
    logic [WIDTH-1:0] po;
    logic             wv, ov, bz;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int bv, si, d, sy, rdy, clr, input int po, input int wv, ov, bz, cnt);
    vec_t v;
    v.bv = 1'(bv);  v.si = 1'(si);  v.d = 1'(d);
    v.sy = 1'(sy);  v.rdy = 1'(rdy); v.clr = 1'(clr);
    v.po = 4'(po);  v.wv = 1'(wv);  v.ov = 1'(ov);
    v.bz = 1'(bz);  v.cnt = 3'(cnt);
    vecs.push_back(v);
  endtask

  // Reference model: bits of the current word kept in arrival order.
  bit               m_bits[$];
  logic             m_dir;
  logic [WIDTH-1:0] m_hold;
  logic             m_valid, m_ovr;

  task automatic model_reset();
    m_bits.delete();
    m_dir   = 1'b0;
    m_hold  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_step(input logic bv, si, d, sy, rdy, clr);
    logic             done, dropped;
    logic [WIDTH-1:0] w;
    done = 1'b0;
    w    = '0;
    if (bv) begin
      if (m_bits.size() == 0 || sy) begin
        m_bits.delete();
        m_dir = d;
      end
      m_bits.push_back(si);
      if (m_bits.size() == WIDTH) begin
        done = 1'b1;
        for (int i = 0; i < WIDTH; i++)
          if (m_dir) w[WIDTH-1-i] = m_bits[i];
          else       w[i] = m_bits[i];
        m_bits.delete();
      end
    end
    dropped = done && m_valid && !rdy;
    if (done && !dropped) begin
      m_hold  = w;
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (dropped)  m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  task automatic send_bit(input int bv, si, d, sy, rdy, clr);
    bit_valid  = 1'(bv);
    serial_in  = 1'(si);
    dir        = 1'(d);
    sync       = 1'(sy);
    word_ready = 1'(rdy);
    clr_ovr    = 1'(clr);
    @(posedge clk);
    #1;
    model_step(bit_valid, serial_in, dir, sync, word_ready, clr_ovr);
  endtask

  task automatic check(input string name, input logic [WIDTH-1:0] po,
                       input logic wv, ov, bz, input logic [CNT_W-1:0] cnt);
    checks++;
    if (parallel_out !== po || word_valid !== wv || overrun !== ov ||
        busy !== bz || bit_count !== cnt) begin
      errors++;
      $display("FAIL %s: got po=%b wv=%b ovr=%b busy=%b cnt=%0d, expected po=%b wv=%b ovr=%b busy=%b cnt=%0d",
               name, parallel_out, word_valid, overrun, busy, bit_count, po, wv, ov, bz, cnt);
    end else begin
      $display("ok   %s: po=%b wv=%b ovr=%b busy=%b cnt=%0d",
               name, parallel_out, word_valid, overrun, busy, bit_count);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_hold, m_valid, m_ovr, m_bits.size() != 0, 3'(m_bits.size()));
  endtask

  initial begin
    // bv si d sy rdy clr | po wv ov busy cnt
    // MSB first 1,1,0,0
    add(1,1,1,1,1,0, 4'b0000,0,0,1,1);
    add(1,1,1,0,1,0, 4'b0000,0,0,1,2);
    add(1,0,1,0,1,0, 4'b0000,0,0,1,3);
    add(1,0,1,0,1,0, 4'b1100,1,0,0,0);
    add(0,0,0,0,1,0, 4'b1100,0,0,0,0);
    // LSB first 1,1,0,0
    add(1,1,0,0,1,0, 4'b1100,0,0,1,1);
    add(1,1,0,0,1,0, 4'b1100,0,0,1,2);
    add(1,0,0,0,1,0, 4'b1100,0,0,1,3);
    add(1,0,0,0,1,0, 4'b0011,1,0,0,0);
    add(0,0,0,0,1,0, 4'b0011,0,0,0,0);
    // Backpressure: 1010 held, 0110 dropped, then clr_ovr
    add(1,1,1,0,0,0, 4'b0011,0,0,1,1);
    add(1,0,1,0,0,0, 4'b0011,0,0,1,2);
    add(1,1,1,0,0,0, 4'b0011,0,0,1,3);
    add(1,0,1,0,0,0, 4'b1010,1,0,0,0);
    add(1,0,1,0,0,0, 4'b1010,1,0,1,1);
    add(1,1,1,0,0,0, 4'b1010,1,0,1,2);
    add(1,1,1,0,0,0, 4'b1010,1,0,1,3);
    add(1,0,1,0,0,0, 4'b1010,1,1,0,0);
    add(0,0,0,0,0,1, 4'b1010,1,0,0,0);
    add(0,0,0,0,1,0, 4'b1010,0,0,0,0);
    // Resync: 1,0 then sync 0,1,1,1
    add(1,1,1,0,1,0, 4'b1010,0,0,1,1);
    add(1,0,1,0,1,0, 4'b1010,0,0,1,2);
    add(1,0,1,1,1,0, 4'b1010,0,0,1,1);
    add(1,1,1,0,1,0, 4'b1010,0,0,1,2);
    add(1,1,1,0,1,0, 4'b1010,0,0,1,3);
    add(1,1,1,0,1,0, 4'b0111,1,0,0,0);
    add(0,0,0,0,1,0, 4'b0111,0,0,0,0);
    // Sync on what would be the last bit restarts; dir is re-latched; gap mid-word
    add(1,1,0,0,1,0, 4'b0111,0,0,1,1);
    add(1,1,0,0,1,0, 4'b0111,0,0,1,2);
    add(1,1,0,0,1,0, 4'b0111,0,0,1,3);
    add(1,0,1,1,1,0, 4'b0111,0,0,1,1);
    add(0,1,0,0,1,0, 4'b0111,0,0,1,1);
    add(1,1,1,0,1,0, 4'b0111,0,0,1,2);
    add(1,0,1,0,1,0, 4'b0111,0,0,1,3);
    add(1,1,1,0,1,0, 4'b0101,1,0,0,0);
    add(0,0,0,0,0,0, 4'b0101,1,0,0,0);
    add(0,0,0,0,1,0, 4'b0101,0,0,0,0);

    rst = 1'b1;
    bit_valid = 1'b0; serial_in = 1'b0; dir = 1'b0;
    sync = 1'b0; word_ready = 1'b0; clr_ovr = 1'b0;
    model_reset();
    #12;
    check("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      send_bit(vecs[i].bv, vecs[i].si, vecs[i].d, vecs[i].sy, vecs[i].rdy, vecs[i].clr);
      check($sformatf("vec%0d", i), vecs[i].po, vecs[i].wv, vecs[i].ov, vecs[i].bz, vecs[i].cnt);
    end

    // Back-to-back: 1010 held, 0011 completes while the consumer takes 1010
    send_bit(1,1,1,0,0,0); send_bit(1,0,1,0,0,0); send_bit(1,1,1,0,0,0); send_bit(1,0,1,0,0,0);
    check("b2b_first_held", 4'b1010, 1'b1, 1'b0, 1'b0, 3'd0);
    send_bit(1,0,1,0,0,0); send_bit(1,0,1,0,0,0); send_bit(1,1,1,0,0,0); send_bit(1,1,1,0,1,0);
    check("b2b_second", 4'b0011, 1'b1, 1'b0, 1'b0, 3'd0);
    send_bit(0,0,0,0,0,0);
    check("b2b_hold", 4'b0011, 1'b1, 1'b0, 1'b0, 3'd0);
    send_bit(0,0,0,0,1,0);
    check("b2b_drain", 4'b0011, 1'b0, 1'b0, 1'b0, 3'd0);

    // clr_ovr coinciding with a new overrun: the set wins
    for (int i = 0; i < WIDTH; i++) send_bit(1,1,1,0,0,0);
    send_bit(1,0,0,0,0,0); send_bit(1,0,0,0,0,0); send_bit(1,0,0,0,0,0); send_bit(1,0,0,0,0,1);
    check("ovr_set_wins", 4'b1111, 1'b1, 1'b1, 1'b0, 3'd0);
    send_bit(0,0,0,0,1,1);
    check("ovr_cleared", 4'b1111, 1'b0, 1'b0, 1'b0, 3'd0);

    // Asynchronous reset mid-word, then 1001
    send_bit(1,1,1,0,1,0); send_bit(1,0,1,0,1,0);
    check("pre_reset_partial", 4'b1111, 1'b0, 1'b0, 1'b1, 3'd2);
    rst = 1'b1;
    #2;
    check("reset_mid_word", 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0);
    rst = 1'b0;
    model_reset();
    send_bit(1,1,1,0,1,0); send_bit(1,0,1,0,1,0); send_bit(1,0,1,0,1,0); send_bit(1,1,1,0,1,0);
    check("after_reset_word", 4'b1001, 1'b1, 1'b0, 1'b0, 3'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      send_bit(($urandom % 4) != 0, $urandom % 2, $urandom % 2,
               ($urandom % 10) == 0, $urandom % 2, ($urandom % 8) == 0);
      check_model($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
